// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants for the instruction fetch front end
`timescale 1ns/1ps
package inst_fetch_unit_pkg;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// rtl/inst_fetch_unit_fifo.sv - synchronous prefetch FIFO with clear and occupancy count
`timescale 1ns/1ps
module inst_fetch_unit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;

  // A push into a full FIFO is only ever paired with a pop; the read port sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q];
  assign count_o    = cnt_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner, imem request issue, prefetch buffering and IF/ID register
`timescale 1ns/1ps
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  pc_sel,
  input  logic                  IF_flush,
  input  logic [ADDR_WIDTH-1:0] alu_target,
  input  logic                  stall,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INST_WIDTH + ADDR_WIDTH;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0]         out_q, out_d, disc_q, disc_d, fifo_count;
  logic [CW:0]           occupancy;
  logic [EW-1:0]         fifo_rdata;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  redirect, req_fire, push, pop;

  assign target = {alu_target[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    redirect       = pc_sel | IF_flush;
    occupancy      = {1'b0, out_q} + {1'b0, fifo_count};
    imem_req_valid = !reset && !redirect && (occupancy < DEPTH_L);
    req_fire       = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && (disc_q == '0) && !redirect;
    pop            = !stall && !redirect && (fifo_count != '0);
    out_d          = out_q + CW'(req_fire) - CW'(imem_rsp_valid);

    // Everything still in flight after this cycle belongs to the wrong path.
    disc_d = disc_q;
    if (redirect) disc_d = out_d;
    else if (imem_rsp_valid && disc_q != '0) disc_d = disc_q - 1'b1;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (push)     resp_pc_d  = resp_pc_q + STEP;
    end

    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (redirect) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (fifo_count != '0) begin
        {inst_d, pc_d} = fifo_rdata;
        valid_d        = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      inst_q     <= NOP_INST;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  inst_fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (redirect),
    .push_i      (push),
    .push_data_i ({imem_rsp_data, resp_pc_q}),
    .pop_i       (pop),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign inst          = inst_q;
  assign inst_pc       = pc_q;
  assign inst_valid    = valid_q;

  a_discard_bound: assert property (@(posedge clk) disable iff (reset) disc_q <= out_q);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit with randomized memory and control
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;
  localparam int          AW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        pc_sel, IF_flush, stall;
  logic [31:0] alu_target, inst, inst_pc;
  logic        inst_valid;

  inst_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc_sel(pc_sel), .IF_flush(IF_flush), .alu_target(alu_target), .stall(stall),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int nvalid = 0;
  int cycle  = 0;
  int ready_pct = 100;
  int lat_min = 1, lat_max = 1;

  logic [31:0] exp_q[$];
  logic [31:0] next_exp;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Program order: sequential from a start PC until the next redirect or reset.
  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    next_exp = pc;
  endtask

  task automatic step(input logic st, input logic ps, input logic fl, input logic [31:0] tgt, input logic rst);
    @(negedge clk);
    #1;
    reset = rst; stall = st; pc_sel = ps; IF_flush = fl; alu_target = tgt;
    if (rst) restart_stream(RPC);
    else if (ps || fl) restart_stream(tgt & 32'hFFFF_FFFC);
    while (exp_q.size() < 32) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  // Memory model: in-order responses after a random latency, random ready.
  initial begin
    logic [31:0] exp_req, prev_addr;
    logic        prev_stuck;
    int          last_due, due;
    exp_req = RPC; prev_stuck = 1'b0; prev_addr = '0; last_due = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      cycle++;
      if (reset) begin
        mq_addr.delete(); mq_due.delete();
        imem_rsp_valid = 1'b0;
        last_due = cycle;
      end else if (mq_due.size() > 0 && mq_due[0] == cycle) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(99) < ready_pct);
      #3;
      if (reset) begin
        exp_req = RPC; prev_stuck = 1'b0;
      end else if (pc_sel || IF_flush) begin
        check("no_req_on_redirect", imem_req_valid, 1'b0);
        exp_req = alu_target & 32'hFFFF_FFFC;
        prev_stuck = 1'b0;
      end else begin
        if (prev_stuck) begin
          check("req_valid_held", imem_req_valid, 1'b1);
          check("req_addr_stable", imem_req_addr, prev_addr);
        end
        if (imem_req_valid) begin
          check("req_addr", imem_req_addr, exp_req);
          if (imem_req_ready) begin
            exp_req = exp_req + 32'd4;
            due = cycle + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
            check("outstanding_bound", mq_due.size() <= DEPTH, 1'b1);
          end
        end
        prev_stuck = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
      end
    end
  end

  // Monitor: inputs seen at the falling edge are those applied at the preceding rising edge.
  initial begin
    logic [31:0] p_inst, p_pc, e_pc;
    logic        p_valid;
    p_inst = NOP_INST; p_pc = '0; p_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_inst", inst, NOP_INST);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_valid", inst_valid, 1'b0);
      end else if (pc_sel || IF_flush) begin
        check("flush_inst", inst, NOP_INST);
        check("flush_valid", inst_valid, 1'b0);
      end else if (stall) begin
        check("stall_hold", {inst, inst_pc}, {p_inst, p_pc});
        check("stall_hold_valid", inst_valid, p_valid);
      end else if (inst_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 1'b0, 1'b1);
        end else begin
          e_pc = exp_q.pop_front();
          check("inst_pc", inst_pc, e_pc);
          check("inst_data", inst, mem_word(e_pc));
          nvalid++;
        end
      end else begin
        check("bubble_nop", inst, NOP_INST);
      end
      p_inst = inst; p_pc = inst_pc; p_valid = inst_valid;
    end
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; IF_flush = 1'b0; alu_target = '0;
    restart_stream(RPC);
    repeat (3) step(0, 0, 0, 32'h0, 1);
    // Streaming with 1-cycle memory latency.
    repeat (20) step(0, 0, 0, 32'h0, 0);
    // Memory refuses requests; buffer drains into bubbles.
    ready_pct = 0;
    repeat (6) step(0, 0, 0, 32'h0, 0);
    check("drained_valid", inst_valid, 1'b0);
    check("blocked_req_valid", imem_req_valid, 1'b1);
    ready_pct = 100;
    repeat (6) step(0, 0, 0, 32'h0, 0);
    // Flush with requests in flight.
    lat_min = 3; lat_max = 3;
    repeat (4) step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h0000_0100, 0);
    repeat (12) step(0, 0, 0, 32'h0, 0);
    lat_min = 1; lat_max = 1;
    // Stall long enough for the buffer to fill.
    repeat (5) step(1, 0, 0, 32'h0, 0);
    check("full_no_req", imem_req_valid, 1'b0);
    repeat (8) step(0, 0, 0, 32'h0, 0);
    // Flush beats stall; pc_sel redirect with unaligned target.
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 1, 32'h0000_0200, 0);
    repeat (3) step(1, 0, 0, 32'h0, 0);
    repeat (8) step(0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0000_0303, 0);
    repeat (8) step(0, 0, 0, 32'h0, 0);
    // Mid-transaction reset.
    lat_min = 2; lat_max = 3;
    repeat (3) step(0, 0, 0, 32'h0, 0);
    repeat (2) step(0, 0, 0, 32'h0, 1);
    repeat (10) step(0, 0, 0, 32'h0, 0);
    // Wrap across the top of the address space.
    step(0, 1, 0, 32'hFFFF_FFF4, 0);
    repeat (12) step(0, 0, 0, 32'h0, 0);
    // Random traffic.
    lat_min = 1; lat_max = 4; ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(99);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      if (r == 0)      step(0, 0, 0, 32'h0, 1);
      else if (r < 4)  step($urandom_range(1), 0, 1, tgt, 0);
      else if (r < 7)  step($urandom_range(1), 1, 0, tgt, 0);
      else             step($urandom_range(99) < 25, 0, 0, 32'h0, 0);
    end
    repeat (10) step(0, 0, 0, 32'h0, 0);
    check("progress", nvalid > 300, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
